seq_multiplier: RTL and testbench
=================================

// Module: seq_multiplier
// PURPOSE
//  Parametrised sequential shift-add multiplier; successor to the combinational 4x4 Multiplier.
//  Takes two WIDTH-bit operands with a start/done handshake and returns a 2*WIDTH-bit product
//  after a fixed WIDTH+1 cycles. Supports unsigned and two's-complement signed mode per operation.
//  Sits on the arithmetic path wherever area matters more than single-cycle throughput.
// PARAMETERS
//  WIDTH      4   operand width in bits (>=2); product is 2*WIDTH bits
//  SIGNED_EN  1   1: sign_mode input honoured; 0: sign_mode ignored, always unsigned
// PORTS
//  clk        in   1         rising-edge clock
//  rst        in   1         asynchronous, active-high reset
//  start      in   1         request; sampled only while busy=0
//  sign_mode  in   1         0 unsigned, 1 signed; latched with operands on accepted start
//  a          in   WIDTH     multiplicand; latched on accepted start
//  b          in   WIDTH     multiplier; latched on accepted start
//  busy       out  1         high from the cycle after an accepted start until done
//  done       out  1         one-cycle pulse: y valid and updated this cycle
//  y          out  2*WIDTH   product; held stable until the next done
// BEHAVIOUR
//  - One clock (clk); reset is asynchronous and active-high (rst): clears all state at once.
//  - Reset values: busy=0, done=0, y=0, FSM=IDLE, internal accumulator/counter=0.
//  - FSM states: IDLE -> RUN -> FIN -> IDLE.
//    IDLE: start=1 at edge E0 -> latch a, b, sign_mode; load |a|, |b| (magnitudes if signed
//          mode and operand negative, else raw); acc=0; cnt=WIDTH; go RUN.
//    RUN : each edge: if mplier LSB=1, acc += mcand (upper half, with carry); shift {acc,mplier}
//          right 1; cnt-=1; after WIDTH RUN edges (edge E0+WIDTH) go FIN.
//    FIN : edge E0+WIDTH+1: y <= neg ? -acc : acc (2*WIDTH bits, two's complement);
//          done=1 for exactly this one cycle; go IDLE.
//  - Latency: done high in the cycle following edge E0+WIDTH+1 (WIDTH+1 cycles after acceptance).
//  - busy = (state != IDLE); done and busy=0 coincide; start in the done cycle is accepted.
//  - start while busy=1: ignored, no queuing; operands not re-sampled.
//  - neg = signed mode & (a[MSB] ^ b[MSB]); zero product never negated to a non-zero value.
//  - Signed edge: most-negative operand magnitude 2^(WIDTH-1) fits unsigned WIDTH bits;
//    (-2^(W-1))*(-2^(W-1)) = 2^(2W-2) fits 2*WIDTH signed result. No overflow possible.
//  - SIGNED_EN=0: sign_mode forced 0 internally; logic for negation may be pruned.
//  - Reset mid-operation: operation abandoned, done never pulses, y returns to 0.
//  - y only changes on done; inputs a, b, sign_mode may change freely while busy.
// STRUCTURE
//  - Include file mult_defs.vh: FSM state encodings (IDLE=2'd0, RUN=2'd1, FIN=2'd2),
//    counter width as $clog2(WIDTH+1) helper, shared by future divider/MAC blocks.
//  - One sub-module natural: mult_sign_fix (combinational WIDTH-bit abs / 2*WIDTH-bit
//    conditional negate), instantiated for operand conditioning and result correction.
//  - Control FSM, counter and shift-add datapath live in seq_multiplier itself.
// TESTING
//  - Unsigned WIDTH=4: a=4, b=2, sign_mode=0, start 1 cycle -> done after 5 cycles, y=8'h08.
//  - Unsigned max: a=15, b=15 -> y=8'hE1 (225); WIDTH=8 a=255, b=255 -> y=16'hFE01.
//  - Signed: a=4'b1000 (-8), b=4'b1000 -> y=8'h40; a=-3 (4'hD), b=5 -> y=8'hF1 (-15);
//    a=0, b=-7 -> y=8'h00.
//  - Start while busy: second start with a=1,b=1 mid-RUN -> ignored, first result delivered,
//    single done pulse; start held high in done cycle -> next op accepted, back-to-back.
//  - Reset mid-op: assert rst 2 cycles after start -> busy=0, done=0, y=0 immediately (async),
//    no done pulse afterwards; new op after release completes correctly.
//  - SIGNED_EN=0 with sign_mode=1, a=4'hD, b=5 -> unsigned result y=8'h41 (65).

Source files
------------

// File: rtl/seq_multiplier_pkg.sv
// rtl/seq_multiplier_pkg.sv - shared FSM encoding and sizing helper for sequential arithmetic blocks
// Purpose: state encoding for the iterative multiplier control FSM and a helper
//          sizing the iteration counter. Shared with future divider/MAC blocks.
// Ports:   none (package)
package seq_multiplier_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } mult_state_e;

    // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_sign_fix.sv
// rtl/mult_sign_fix.sv - combinational conditional two's-complement negate
// Purpose: val_o = neg_i ? -val_i : val_i. Used as |x| on operands (neg_i = operand
//          is negative) and as result sign correction on the product.
// Ports:   val_i [N-1:0] value in, neg_i negate request, val_o [N-1:0] value out
module mult_sign_fix #(
    parameter int N = 4
) (
    input  logic [N-1:0] val_i,
    input  logic         neg_i,
    output logic [N-1:0] val_o
);

    // -(-2^(N-1)) wraps to 2^(N-1), which is exactly the unsigned magnitude we want.
    assign val_o = neg_i ? (~val_i + N'(1)) : val_i;

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - sequential shift-add multiplier, unsigned or signed per operation
// Purpose: multiplies two WIDTH-bit operands in WIDTH shift-add steps, result is a
//          2*WIDTH-bit product delivered with a one-cycle done pulse WIDTH+1 cycles
//          after an accepted start.
// Ports:   clk, rst (async, active-high)
//          start, sign_mode, a, b : request and operands, sampled while idle
//          busy, done, y          : status, result-valid pulse, held product
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               sign_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] y
);

    localparam int CW = cnt_width(WIDTH);

    mult_state_e        state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] y_q, y_d;
    logic               done_q, done_d;

    logic               sign_eff;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH:0]     add_sum;

    assign sign_eff = SIGNED_EN && sign_mode;

    mult_sign_fix #(.N(WIDTH)) u_abs_a (
        .val_i (a),
        .neg_i (sign_eff & a[WIDTH-1]),
        .val_o (a_mag)
    );

    mult_sign_fix #(.N(WIDTH)) u_abs_b (
        .val_i (b),
        .neg_i (sign_eff & b[WIDTH-1]),
        .val_o (b_mag)
    );

    // After WIDTH steps {acc, mplier} holds the full unsigned magnitude product.
    mult_sign_fix #(.N(2*WIDTH)) u_fix_y (
        .val_i ({acc_q, mplier_q}),
        .neg_i (neg_q),
        .val_o (prod_fixed)
    );

    // One extra bit keeps the carry out of the upper-half add for the shift.
    assign add_sum = mplier_q[0] ? ({1'b0, acc_q} + {1'b0, mcand_q}) : {1'b0, acc_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            y_q      <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            y_q      <= y_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        y_d      = y_q;
        done_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mcand_d  = a_mag;
                    mplier_d = b_mag;
                    acc_d    = '0;
                    cnt_d    = CW'(WIDTH);
                    neg_d    = sign_eff & (a[WIDTH-1] ^ b[WIDTH-1]);
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                // Shift {carry, acc, mplier} right by one; multiplier bits retire from
                // the bottom while product bits fill in from the top.
                acc_d    = add_sum[WIDTH:1];
                mplier_d = {add_sum[0], mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                y_d     = prod_fixed;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign y    = y_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - self-checking bench for seq_multiplier
module tb_seq_multiplier;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // sel 0: WIDTH=4 signed-capable; 1: WIDTH=8 signed-capable; 2: WIDTH=4 SIGNED_EN=0
    logic       start4 = 1'b0, start8 = 1'b0, startu = 1'b0;
    logic       sm4 = 1'b0, sm8 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy4, done4, busy8, done8, busyu, doneu;
    logic [7:0] y4, yu;
    logic [15:0] y8;

    seq_multiplier #(.WIDTH(4), .SIGNED_EN(1'b1)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .sign_mode(sm4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .y(y4));
    seq_multiplier #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sign_mode(sm8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .y(y8));
    seq_multiplier #(.WIDTH(4), .SIGNED_EN(1'b0)) dutu (
        .clk(clk), .rst(rst), .start(startu), .sign_mode(sm4), .a(a4), .b(b4),
        .busy(busyu), .done(doneu), .y(yu));

    int sel = 0;
    logic        obs_busy, obs_done;
    logic [15:0] obs_y;
    always_comb begin
        obs_busy = busy4;
        obs_done = done4;
        obs_y    = {8'h00, y4};
        case (sel)
            1: begin obs_busy = busy8; obs_done = done8; obs_y = y8; end
            2: begin obs_busy = busyu; obs_done = doneu; obs_y = {8'h00, yu}; end
            default: ;
        endcase
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: integer product of the operands as numbers, reduced mod 2^(2w).
    function automatic longint ref_mul(input int av, input int bv, input bit sgn, input int w);
        longint ia = av;
        longint ib = bv;
        longint lim = longint'(1) << (w - 1);
        longint p;
        if (sgn) begin
            if (ia >= lim) ia = ia - 2 * lim;
            if (ib >= lim) ib = ib - 2 * lim;
        end
        p = ia * ib;
        return p & ((longint'(1) << (2 * w)) - 1);
    endfunction

    function automatic int width_of(input int s);
        return (s == 1) ? 8 : 4;
    endfunction

    task automatic set_start(input int s, input logic v);
        case (s)
            1: start8 = v;
            2: startu = v;
            default: start4 = v;
        endcase
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (obs_done !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic do_op(input string tag, input int s, input int av, input int bv, input logic smv);
        int n;
        int w = width_of(s);
        sel = s;
        if (s == 1) begin a8 = 8'(av); b8 = 8'(bv); sm8 = smv; end
        else begin a4 = 4'(av); b4 = 4'(bv); sm4 = smv; end
        set_start(s, 1'b1);
        @(posedge clk); #1;
        set_start(s, 1'b0);
        chk({tag, ".busy"}, 64'(obs_busy), 64'(1));
        wait_done(n);
        chk({tag, ".lat"}, 64'(n), 64'(w + 1));
        chk({tag, ".y"}, 64'(obs_y), 64'(ref_mul(av, bv, (s != 2) && smv, w)));
        chk({tag, ".busy_at_done"}, 64'(obs_busy), 64'(0));
        @(posedge clk); #1;
        chk({tag, ".pulse"}, 64'(obs_done), 64'(0));
    endtask

    initial begin
        int n;
        int dcount;
        logic [3:0] ra, rb;
        logic [7:0] r8a, r8b;
        logic rs;

        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy4", 64'(busy4), 64'(0));
        chk("rst.done4", 64'(done4), 64'(0));
        chk("rst.y4", 64'(y4), 64'(0));
        chk("rst.y8", 64'(y8), 64'(0));
        chk("rst.yu", 64'(yu), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle.busy4", 64'(busy4), 64'(0));

        // Directed cases
        do_op("u4x2", 0, 4, 2, 1'b0);
        chk("u4x2.const", 64'(y4), 64'h08);
        do_op("u15x15", 0, 15, 15, 1'b0);
        chk("u15x15.const", 64'(y4), 64'hE1);
        do_op("s-8x-8", 0, 8, 8, 1'b1);
        chk("s-8x-8.const", 64'(y4), 64'h40);
        do_op("s-3x5", 0, 13, 5, 1'b1);
        chk("s-3x5.const", 64'(y4), 64'hF1);
        do_op("s0x-7", 0, 0, 9, 1'b1);
        chk("s0x-7.const", 64'(y4), 64'h00);
        do_op("u255x255", 1, 255, 255, 1'b0);
        chk("u255x255.const", 64'(y8), 64'hFE01);
        do_op("se0", 2, 13, 5, 1'b1);
        chk("se0.const", 64'(yu), 64'h41);

        // Randomized cases against the reference
        for (int i = 0; i < 12; i++) begin
            ra = 4'($urandom_range(0, 15)); rb = 4'($urandom_range(0, 15));
            rs = 1'($urandom_range(0, 1));
            do_op("rnd4", 0, int'(ra), int'(rb), rs);
            r8a = 8'($urandom_range(0, 255)); r8b = 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            do_op("rnd8", 1, int'(r8a), int'(r8b), rs);
        end
        do_op("s-128x-128", 1, 128, 128, 1'b1);
        do_op("s-128x127", 1, 128, 127, 1'b1);

        // Start while busy is ignored; operands not re-sampled
        sel = 0;
        a4 = 4'd3; b4 = 4'd5; sm4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        a4 = 4'd1; b4 = 4'd1; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        wait_done(n);
        chk("busystart.lat", 64'(n + 2), 64'(5));
        chk("busystart.y", 64'(y4), 64'(15));
        @(posedge clk); #1;
        chk("busystart.pulse", 64'(done4), 64'(0));
        chk("busystart.noqueue", 64'(busy4), 64'(0));

        // Start held high through done: back-to-back acceptance
        a4 = 4'd6; b4 = 4'd7; sm4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        a4 = 4'd2; b4 = 4'd3;
        wait_done(n);
        chk("b2b.lat1", 64'(n), 64'(5));
        chk("b2b.y1", 64'(y4), 64'(42));
        @(posedge clk); #1;
        chk("b2b.accepted", 64'(busy4), 64'(1));
        start4 = 1'b0;
        wait_done(n);
        chk("b2b.lat2", 64'(n), 64'(5));
        chk("b2b.y2", 64'(y4), 64'(6));
        @(posedge clk); #1;

        // Asynchronous reset mid-operation
        a4 = 4'd3; b4 = 4'd5; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("midrst.busy", 64'(busy4), 64'(0));
        chk("midrst.done", 64'(done4), 64'(0));
        chk("midrst.y", 64'(y4), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done4 === 1'b1) dcount++;
        end
        chk("midrst.nodone", 64'(dcount), 64'(0));
        do_op("after_rst", 0, 11, 6, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
